// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Bundle of raster timing outputs from the VGA timing generator.
//   master: driven by vga_timing_controller.
//   slave : pixel colour logic, DAC glue and game logic.
//
//   x, y         raw horizontal / vertical counters (10 bits each)
//   hsync, vsync active-low sync pulses
//   blank_n      high only inside the visible region
//   sync_n       DAC composite sync (constant 0)
//   vga_clk      pixel clock to the DAC, 50 % duty
//   pix_tick     one-clk strobe per pixel
//   frame_start  one-clk pulse after the raster returns to (0,0)
//   blink        slow toggle for cursor blinking
interface vga_timing_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       sync_n;
    logic       vga_clk;
    logic       pix_tick;
    logic       frame_start;
    logic       blink;

    modport master (
        output x, y, hsync, vsync, blank_n, sync_n,
               vga_clk, pix_tick, frame_start, blink
    );

    modport slave (
        input  x, y, hsync, vsync, blank_n, sync_n,
               vga_clk, pix_tick, frame_start, blink
    );
endinterface

// File: rtl/vga_timing_controller.sv
// vga_timing_controller
//   Generates 640x480 @ 60 Hz VGA raster timing from the 50 MHz system clock.
//   A clock divider produces the pixel strobe and the DAC pixel clock; x/y
//   counters walk the full raster including blanking, and registered
//   sync/blank outputs are decoded from the next-state counter values so they
//   change on the same edge as x/y.
//
//   Ports:
//     clk  in   system clock (only clock)
//     rst  in   asynchronous, active-high reset
//     vga  vga_timing_if.master  raster outputs (see vga_timing_if)
//
//   Optional feature macro: VGA_BLINK_EN
//     defined   : frame counter (0..BLINK_FRAMES-1) toggles blink on each wrap
//     undefined : no frame counter, blink is constant 0
module vga_timing_controller #(
    parameter int CLK_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time guards on the parameter set.
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("vga_timing_controller: CLK_DIV must be even and >= 2");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_controller: raster totals exceed 10-bit counters");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("vga_timing_controller: BLINK_FRAMES must be >= 1");
    end

    logic [DIV_W-1:0] div_cnt_p0, div_cnt_p1;
    logic [9:0]       x_p0, x_p1;
    logic [9:0]       y_p0, y_p1;
    logic             tick_p0, tick_p1;
    logic             vclk_p0, vclk_p1;
    logic             hsync_p0, hsync_p1;
    logic             vsync_p0, vsync_p1;
    logic             blank_n_p0, blank_n_p1;
    logic             frame_wrap_p0, frame_start_p1;

    // ---- stage p0: next-state counters and decoded timing -------------------
    // tick_p1 is high exactly while div_cnt_p1 == CLK_DIV-1, so the counters
    // advance on the edge that ends each pixel's last system clock.
    always_comb begin
        div_cnt_p0    = (div_cnt_p1 == DIV_LAST) ? '0 : div_cnt_p1 + 1'b1;
        x_p0          = x_p1;
        y_p0          = y_p1;
        frame_wrap_p0 = 1'b0;
        if (tick_p1) begin
            if (x_p1 == H_LAST) begin
                x_p0 = '0;
                if (y_p1 == V_LAST) begin
                    y_p0          = '0;
                    frame_wrap_p0 = 1'b1;
                end else begin
                    y_p0 = y_p1 + 1'b1;
                end
            end else begin
                x_p0 = x_p1 + 1'b1;
            end
        end
        tick_p0    = (div_cnt_p0 == DIV_LAST);
        vclk_p0    = (div_cnt_p0 >= DIV_HALF);
        hsync_p0   = !((x_p0 >= HS_START) && (x_p0 < HS_END));
        vsync_p0   = !((y_p0 >= VS_START) && (y_p0 < VS_END));
        blank_n_p0 = (x_p0 < H_ACT) && (y_p0 < V_ACT);
    end

    // ---- stage p1: registered raster state and outputs ----------------------
    // frame_start_p1 is loaded on the same edge that moves the raster to (0,0),
    // so it is high for the one clk that immediately follows that transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_p1     <= '0;
            x_p1           <= '0;
            y_p1           <= '0;
            tick_p1        <= 1'b0;
            vclk_p1        <= 1'b0;
            hsync_p1       <= 1'b1;
            vsync_p1       <= 1'b1;
            blank_n_p1     <= 1'b0;
            frame_start_p1 <= 1'b0;
        end else begin
            div_cnt_p1     <= div_cnt_p0;
            x_p1           <= x_p0;
            y_p1           <= y_p0;
            tick_p1        <= tick_p0;
            vclk_p1        <= vclk_p0;
            hsync_p1       <= hsync_p0;
            vsync_p1       <= vsync_p0;
            blank_n_p1     <= blank_n_p0;
            frame_start_p1 <= frame_wrap_p0;
        end
    end

`ifdef VGA_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_p2;
    logic            blink_p2;

    // ---- stage p2: frame counter and blink toggle ---------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_p2 <= '0;
            blink_p2     <= 1'b0;
        end else if (frame_start_p1) begin
            if (frame_cnt_p2 == FC_LAST) begin
                frame_cnt_p2 <= '0;
                blink_p2     <= ~blink_p2;
            end else begin
                frame_cnt_p2 <= frame_cnt_p2 + 1'b1;
            end
        end
    end

    assign vga.blink = blink_p2;
`else
    assign vga.blink = 1'b0;
`endif

    assign vga.x           = x_p1;
    assign vga.y           = y_p1;
    assign vga.hsync       = hsync_p1;
    assign vga.vsync       = vsync_p1;
    assign vga.blank_n     = blank_n_p1;
    assign vga.sync_n      = 1'b0;
    assign vga.vga_clk     = vclk_p1;
    assign vga.pix_tick    = tick_p1;
    assign vga.frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller
//   Bench for vga_timing_controller with a reduced raster (80 x 8) so whole
//   frames run quickly. Expected outputs come from a closed-form model indexed
//   by the number of clk edges since reset release; they are queued as each
//   edge is driven and popped for comparison 1 time unit after the edge.
module tb_vga_timing_controller;
    localparam int CLK_DIV      = 2;
    localparam int H_ACTIVE     = 64;
    localparam int H_FP         = 4;
    localparam int H_SYNC       = 8;
    localparam int H_BP         = 4;
    localparam int V_ACTIVE     = 4;
    localparam int V_FP         = 1;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LINE_CLK     = CLK_DIV * H_TOTAL;
    localparam int FRAME_CLK    = LINE_CLK * V_TOTAL;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_if vif ();

    vga_timing_controller #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
        .H_BP(H_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
        .V_BP(V_BP), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
        logic       blank_n;
        logic       vga_clk;
        logic       pix_tick;
        logic       frame_start;
        logic       blink;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint n_edges = 0;

    // Expected outputs after n clk edges since reset release (n=0: reset state).
    function automatic exp_t model(longint n);
        exp_t   e;
        longint d, ticks, px, ln;
        d     = n % CLK_DIV;
        ticks = n / CLK_DIV;
        px    = ticks % H_TOTAL;
        ln    = (ticks / H_TOTAL) % V_TOTAL;
        e.x        = 10'(px);
        e.y        = 10'(ln);
        e.pix_tick = (d == CLK_DIV - 1);
        e.vga_clk  = (d >= CLK_DIV / 2);
        if (n == 0) begin
            e.hsync   = 1'b1;
            e.vsync   = 1'b1;
            e.blank_n = 1'b0;
        end else begin
            e.hsync   = !(px >= H_ACTIVE + H_FP && px < H_ACTIVE + H_FP + H_SYNC);
            e.vsync   = !(ln >= V_ACTIVE + V_FP && ln < V_ACTIVE + V_FP + V_SYNC);
            e.blank_n = (px < H_ACTIVE) && (ln < V_ACTIVE);
        end
        e.frame_start = (n > 0) && (n % FRAME_CLK == 0);
        e.blink       = 1'b0;
`ifdef VGA_BLINK_EN
        if (n > 0) e.blink = ((((n - 1) / FRAME_CLK) / BLINK_FRAMES) % 2) == 1;
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        n_edges++;
        sb.push_back(model(n_edges));
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_edges = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        int   hit;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (vif.x !== 10'd0 || vif.y !== 10'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1 ||
            vif.blank_n !== 1'b0 || vif.pix_tick !== 1'b0 || vif.vga_clk !== 1'b0 ||
            vif.frame_start !== 1'b0 || vif.blink !== 1'b0 || vif.sync_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: x=%0d y=%0d hs=%b vs=%b bn=%b pt=%b vc=%b fs=%b bl=%b sn=%b, need 0 0 1 1 0 0 0 0 0 0",
                     vif.x, vif.y, vif.hsync, vif.vsync, vif.blank_n, vif.pix_tick,
                     vif.vga_clk, vif.frame_start, vif.blink, vif.sync_n);
        end
        rst = 1'b0;
        n_edges = 0;
        sb.delete();
        step();
        e = sb.pop_front();
        n_cmp++;
        if (vif.blank_n !== 1'b1 || vif.pix_tick !== e.pix_tick || vif.pix_tick !== 1'b1) begin
            n_err++;
            $display("FAIL release_first_edge: blank_n=%b pix_tick=%b, need 1 1", vif.blank_n, vif.pix_tick);
        end
        // run to mid-frame (x=30, y=2), then assert rst between edges
        hit = 0;
        for (int i = 0; i < FRAME_CLK && hit == 0; i++) begin
            step();
            e = sb.pop_front();
            if (vif.x == 10'd30 && vif.y == 10'd2) hit = 1;
        end
        n_cmp++;
        if (hit == 0) begin
            n_err++;
            $display("FAIL midframe_reach: x=%0d y=%0d, need 30 2 within budget", vif.x, vif.y);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (vif.x !== 10'd0 || vif.y !== 10'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1 ||
            vif.blank_n !== 1'b0 || vif.frame_start !== 1'b0 || vif.pix_tick !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: x=%0d y=%0d hs=%b vs=%b bn=%b fs=%b pt=%b, need 0 0 1 1 0 0 0",
                     vif.x, vif.y, vif.hsync, vif.vsync, vif.blank_n, vif.frame_start, vif.pix_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        n_edges = 0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (vif.x !== e.x || vif.y !== e.y || vif.frame_start !== e.frame_start ||
                vif.blank_n !== e.blank_n || vif.pix_tick !== e.pix_tick) begin
                n_err++;
                $display("FAIL restart_raster: edge %0d got x=%0d y=%0d fs=%b bn=%b pt=%b, need %0d %0d %b %b %b",
                         n_edges, vif.x, vif.y, vif.frame_start, vif.blank_n, vif.pix_tick,
                         e.x, e.y, e.frame_start, e.blank_n, e.pix_tick);
            end
        end
    endtask

    task automatic test_horizontal();
        exp_t   e;
        logic   prev_hs, prev_bn;
        longint last_rise;
        int     rises;
        reset_release();
        rises = 0;
        last_rise = -1;
        for (int i = 0; i < 2 * LINE_CLK + 4; i++) begin
            prev_hs = vif.hsync;
            prev_bn = vif.blank_n;
            step();
            e = sb.pop_front();
            n_cmp++;
            if (vif.x !== e.x || vif.hsync !== e.hsync || vif.blank_n !== e.blank_n) begin
                n_err++;
                $display("FAIL horiz_cycle: edge %0d got x=%0d hs=%b bn=%b, need %0d %b %b",
                         n_edges, vif.x, vif.hsync, vif.blank_n, e.x, e.hsync, e.blank_n);
            end
            if (prev_hs === 1'b1 && vif.hsync === 1'b0) begin
                n_cmp++;
                if (vif.x !== 10'(H_ACTIVE + H_FP)) begin
                    n_err++;
                    $display("FAIL hsync_fall_x: x=%0d, need %0d", vif.x, H_ACTIVE + H_FP);
                end
            end
            if (prev_hs === 1'b0 && vif.hsync === 1'b1) begin
                n_cmp++;
                if (vif.x !== 10'(H_ACTIVE + H_FP + H_SYNC)) begin
                    n_err++;
                    $display("FAIL hsync_rise_x: x=%0d, need %0d", vif.x, H_ACTIVE + H_FP + H_SYNC);
                end
                if (last_rise >= 0) begin
                    n_cmp++;
                    if (n_edges - last_rise != LINE_CLK) begin
                        n_err++;
                        $display("FAIL hsync_period: got %0d clk, need %0d", n_edges - last_rise, LINE_CLK);
                    end
                end
                last_rise = n_edges;
                rises++;
            end
            if (prev_bn === 1'b1 && vif.blank_n === 1'b0) begin
                n_cmp++;
                if (vif.x !== 10'(H_ACTIVE)) begin
                    n_err++;
                    $display("FAIL blank_fall_x: x=%0d, need %0d", vif.x, H_ACTIVE);
                end
            end
        end
        n_cmp++;
        if (rises != 2) begin
            n_err++;
            $display("FAIL hsync_rise_count: got %0d, need 2", rises);
        end
    endtask

    task automatic test_vertical();
        exp_t e;
        int   vs_low;
        reset_release();
        vs_low = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            step();
            e = sb.pop_front();
            n_cmp++;
            if (vif.y !== e.y || vif.vsync !== e.vsync) begin
                n_err++;
                $display("FAIL vert_cycle: edge %0d got y=%0d vs=%b, need %0d %b",
                         n_edges, vif.y, vif.vsync, e.y, e.vsync);
            end
            if (vif.vsync === 1'b0) begin
                vs_low++;
                if (vif.y < 10'(V_ACTIVE + V_FP) || vif.y >= 10'(V_ACTIVE + V_FP + V_SYNC)) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL vsync_low_y: y=%0d, need %0d..%0d", vif.y,
                             V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
                end
            end
            if (vif.y >= 10'(V_ACTIVE) && vif.blank_n !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL vblank: y=%0d blank_n=%b, need 0", vif.y, vif.blank_n);
            end
        end
        n_cmp++;
        if (vs_low != V_SYNC * LINE_CLK) begin
            n_err++;
            $display("FAIL vsync_low_len: got %0d clk, need %0d", vs_low, V_SYNC * LINE_CLK);
        end
    endtask

    task automatic test_frame_marker();
        exp_t       e;
        logic [9:0] px, py;
        logic       prev_fs;
        longint     last_fs;
        int         pulses;
        reset_release();
        pulses = 0;
        last_fs = -1;
        for (int i = 0; i < 3 * FRAME_CLK + 2; i++) begin
            px = vif.x;
            py = vif.y;
            prev_fs = vif.frame_start;
            step();
            e = sb.pop_front();
            n_cmp++;
            if (vif.frame_start !== e.frame_start) begin
                n_err++;
                $display("FAIL frame_start_cycle: edge %0d got %b, need %b", n_edges, vif.frame_start, e.frame_start);
            end
            if (vif.frame_start === 1'b1) begin
                pulses++;
                n_cmp++;
                if (prev_fs !== 1'b0 || px !== 10'(H_TOTAL - 1) || py !== 10'(V_TOTAL - 1) ||
                    vif.x !== 10'd0 || vif.y !== 10'd0) begin
                    n_err++;
                    $display("FAIL frame_start_pos: prev_fs=%b from (%0d,%0d) to (%0d,%0d), need 0 from (%0d,%0d) to (0,0)",
                             prev_fs, px, py, vif.x, vif.y, H_TOTAL - 1, V_TOTAL - 1);
                end
                if (last_fs >= 0) begin
                    n_cmp++;
                    if (n_edges - last_fs != FRAME_CLK) begin
                        n_err++;
                        $display("FAIL frame_spacing: got %0d clk, need %0d", n_edges - last_fs, FRAME_CLK);
                    end
                end
                last_fs = n_edges;
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL frame_count: got %0d, need 3", pulses);
        end
    endtask

    task automatic test_pixel_clock();
        exp_t       e;
        logic [9:0] px;
        logic       prev_pt, prev_vc;
        int         hi, lo;
        hi = 0;
        lo = 0;
        for (int i = 0; i < 2 * LINE_CLK; i++) begin
            px = vif.x;
            prev_pt = vif.pix_tick;
            prev_vc = vif.vga_clk;
            step();
            e = sb.pop_front();
            n_cmp++;
            if (vif.x !== e.x || vif.y !== e.y || vif.hsync !== e.hsync || vif.vsync !== e.vsync ||
                vif.blank_n !== e.blank_n || vif.vga_clk !== e.vga_clk || vif.pix_tick !== e.pix_tick ||
                vif.frame_start !== e.frame_start || vif.blink !== e.blink || vif.sync_n !== 1'b0) begin
                n_err++;
                $display("FAIL full_cycle: edge %0d got x=%0d y=%0d hs=%b vs=%b bn=%b vc=%b pt=%b fs=%b bl=%b, need %0d %0d %b %b %b %b %b %b %b",
                         n_edges, vif.x, vif.y, vif.hsync, vif.vsync, vif.blank_n, vif.vga_clk,
                         vif.pix_tick, vif.frame_start, vif.blink, e.x, e.y, e.hsync, e.vsync,
                         e.blank_n, e.vga_clk, e.pix_tick, e.frame_start, e.blink);
            end
            if (vif.x !== px && prev_pt !== 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL x_without_tick: x %0d->%0d with pix_tick=%b", px, vif.x, prev_pt);
            end
            // CLK_DIV=2: vga_clk must toggle on every clk edge
            n_cmp++;
            if (vif.vga_clk === prev_vc) begin
                n_err++;
                $display("FAIL vga_clk_toggle: edge %0d got %b, need %b", n_edges, vif.vga_clk, ~prev_vc);
            end
            if (vif.vga_clk === 1'b1) hi++;
            else lo++;
        end
        n_cmp++;
        if (hi != lo) begin
            n_err++;
            $display("FAIL vga_clk_duty: high=%0d low=%0d, need equal", hi, lo);
        end
    endtask

    task automatic test_blink();
        exp_t   e;
        logic   prev_bl;
        int     toggles;
        longint tog_at[$];
        reset_release();
        toggles = 0;
        for (int i = 0; i < 6 * FRAME_CLK + 4; i++) begin
            prev_bl = vif.blink;
            step();
            e = sb.pop_front();
            n_cmp++;
            if (vif.blink !== e.blink) begin
                n_err++;
                $display("FAIL blink_cycle: edge %0d got %b, need %b", n_edges, vif.blink, e.blink);
            end
            if (vif.blink !== prev_bl) begin
                toggles++;
                tog_at.push_back(n_edges);
            end
        end
`ifdef VGA_BLINK_EN
        n_cmp++;
        if (toggles != 3) begin
            n_err++;
            $display("FAIL blink_toggles: got %0d, need 3", toggles);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (tog_at[k] != longint'((2 * k + 2) * FRAME_CLK + 1)) begin
                    n_err++;
                    $display("FAIL blink_toggle_edge: toggle %0d at %0d, need %0d",
                             k, tog_at[k], (2 * k + 2) * FRAME_CLK + 1);
                end
            end
        end
`else
        n_cmp++;
        if (toggles != 0 || vif.blink !== 1'b0) begin
            n_err++;
            $display("FAIL blink_static: toggles=%0d blink=%b, need 0 0", toggles, vif.blink);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_pixel_clock();
        test_frame_marker();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
